ntt_seq_ctrl: RTL and testbench

- Pass sequencer that sits directly upstream of the poly_mul datapath.
- Drives its `sel`, `ntt_l` and `tf_address` inputs for each operation.
- Generates read/write addresses and bank selects for the two ping-pong coefficient RAMs that feed and capture it: 32 words of 8 coefficients per bank.
- Covers full NTT (8 passes), INTT (8 passes), and one-pass pointwise MULT/ADD. Reports busy/done to the top-level FSM.

---
 rtl/ntt_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_ntt_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_seq_ctrl.sv
// Pass sequencer for the poly_mul datapath: steps NTT/INTT passes or a single pointwise pass,
// generating ping-pong RAM addresses, bank selects, mode and twiddle addresses.
module ntt_seq_ctrl #(
    parameter int NTT_LAT  = 5,
    parameter int INTT_LAT = 5,
    parameter int PW_LAT   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic       busy,
    output logic       done,
    output logic [2:0] sel,
    output logic [1:0] ntt_l,
    output logic [7:0] tf_address,
    output logic       rd_en,
    output logic [4:0] rd_addr,
    output logic       rd_bank,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic       wr_bank
);

    localparam int LAT_A   = (NTT_LAT > INTT_LAT) ? NTT_LAT : INTT_LAT;
    localparam int MAX_LAT = (LAT_A > PW_LAT) ? LAT_A : PW_LAT;
    localparam int TAP_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

    state_e     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [2:0] pass_q, pass_d;
    logic [4:0] cnt_q, cnt_d;
    logic [MAX_LAT-1:0] vld_q;
    logic [4:0] addr_q [MAX_LAT];

    logic       is_pw;
    logic       last_pass;
    logic [4:0] lat;
    logic [4:0] lat_m1;
    logic [2:0] layer;
    logic [7:0] tf_base;
    logic [4:0] cnt_sh;

    assign is_pw     = op_q[1];
    assign last_pass = is_pw || (pass_q == 3'd7);
    assign lat       = (op_q == 2'b00) ? 5'(NTT_LAT) :
                       (op_q == 2'b01) ? 5'(INTT_LAT) : 5'(PW_LAT);
    assign lat_m1    = lat - 5'd1;
    // INTT walks the layers in reverse order
    assign layer     = (op_q == 2'b01) ? (3'd7 - pass_q) : pass_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            pass_q  <= 3'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = op;
                    pass_d  = 3'd0;
                    cnt_d   = 5'd0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == lat_m1) begin
                    cnt_d = 5'd0;
                    if (last_pass) begin
                        state_d = FIN;
                    end else begin
                        pass_d  = pass_q + 3'd1;
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write strobe/address are the read strobe/address delayed by the op's latency
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < MAX_LAT; i++) addr_q[i] <= 5'd0;
        end else begin
            vld_q     <= {vld_q[MAX_LAT-2:0], rd_en};
            addr_q[0] <= rd_addr;
            for (int i = 1; i < MAX_LAT; i++) addr_q[i] <= addr_q[i-1];
        end
    end

    assign tf_base = (8'd1 << layer) - 8'd1;
    assign cnt_sh  = cnt_q >> (3'd5 - layer);

    always_comb begin
        busy       = (state_q == RUN) || (state_q == DRAIN);
        done       = (state_q == FIN);
        rd_en      = (state_q == RUN);
        rd_addr    = rd_en ? cnt_q : 5'd0;
        wr_en      = vld_q[lat_m1[TAP_W-1:0]];
        wr_addr    = addr_q[lat_m1[TAP_W-1:0]];
        sel        = 3'b000;
        ntt_l      = 2'd0;
        tf_address = 8'd0;
        rd_bank    = 1'b0;
        wr_bank    = 1'b0;
        if (busy) begin
            case (op_q)
                2'b00:   sel = 3'b001;
                2'b01:   sel = 3'b100;
                2'b10:   sel = 3'b010;
                default: sel = 3'b110;
            endcase
            if (is_pw) begin
                ntt_l   = 2'd2;
                wr_bank = 1'b1;
            end else begin
                ntt_l   = (layer == 3'd7) ? 2'd2 : (layer == 3'd6) ? 2'd1 : 2'd0;
                rd_bank = pass_q[0];
                wr_bank = ~pass_q[0];
                if (rd_en) begin
                    tf_address = (layer <= 3'd5) ? (tf_base + {3'b000, cnt_sh})
                                                 : (8'd63 + {3'b000, cnt_q});
                end
            end
        end
    end

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Directed self-checking bench for ntt_seq_ctrl: records per-cycle output traces of each
// operation and compares them against hand-derived schedules.
module tb_ntt_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic       busy, done, rd_en, rd_bank, wr_en, wr_bank;
    logic [2:0] sel;
    logic [1:0] ntt_l;
    logic [7:0] tf_address;
    logic [4:0] rd_addr, wr_addr;

    int checks = 0;
    int failures = 0;

    localparam int MAXC = 320;
    logic       busy_t [MAXC];
    logic       done_t [MAXC];
    logic       rden_t [MAXC];
    logic       rdbk_t [MAXC];
    logic       wren_t [MAXC];
    logic       wrbk_t [MAXC];
    logic [2:0] sel_t  [MAXC];
    logic [1:0] nl_t   [MAXC];
    logic [7:0] tf_t   [MAXC];
    logic [4:0] rda_t  [MAXC];
    logic [4:0] wra_t  [MAXC];

    ntt_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .busy(busy), .done(done), .sel(sel), .ntt_l(ntt_l), .tf_address(tf_address),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank)
    );

    always #5 clk = ~clk;

    // Pulse start with op o, then record ncyc cycles; cycle 1 is the first cycle after acceptance.
    task automatic run_op(input logic [1:0] o, input int ncyc, input int spur_at,
                          input logic [1:0] spur_op, input int rst_at);
        @(negedge clk);
        op = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = ~o;
        for (int k = 1; k <= ncyc; k++) begin
            busy_t[k] = busy; done_t[k] = done; rden_t[k] = rd_en; rdbk_t[k] = rd_bank;
            wren_t[k] = wr_en; wrbk_t[k] = wr_bank; sel_t[k] = sel; nl_t[k] = ntt_l;
            tf_t[k] = tf_address; rda_t[k] = rd_addr; wra_t[k] = wr_addr;
            start = (k == spur_at);
            if (k == spur_at) op = spur_op;
            rst = (k == rst_at);
            @(negedge clk);
        end
        start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, sel, ntt_l, tf_address, rd_en, rd_addr, rd_bank, wr_en, wr_addr, wr_bank} !== 28'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b sel=%b rd_en=%b wr_en=%b tf=%0d, required all 0",
                     busy, done, sel, rd_en, wr_en, tf_address);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b rd_en=%b, required 0 0", busy, rd_en);
        end
    endtask

    task automatic test_ntt();
        int nb, nd, nr, nw, ns;
        logic [7:0] exp_tf;
        run_op(2'b00, 300, 0, 2'b00, 0);
        nb = 0; nd = 0; nr = 0; nw = 0; ns = 0;
        for (int k = 1; k <= 300; k++) begin
            nb += int'(busy_t[k]); nd += int'(done_t[k]);
            nr += int'(rden_t[k]); nw += int'(wren_t[k]);
            ns += int'(sel_t[k] === 3'b001);
        end
        checks++; if (busy_t[1] !== 1'b1) begin failures++; $display("FAIL ntt_busy_rise: got %b required 1", busy_t[1]); end
        checks++; if (nb !== 296) begin failures++; $display("FAIL ntt_busy_cycles: got %0d required 296", nb); end
        checks++; if (ns !== 296) begin failures++; $display("FAIL ntt_sel_cycles: got %0d required 296", ns); end
        checks++; if (nr !== 256) begin failures++; $display("FAIL ntt_rd_count: got %0d required 256", nr); end
        checks++; if (nw !== 256) begin failures++; $display("FAIL ntt_wr_count: got %0d required 256", nw); end
        checks++; if (nd !== 1 || done_t[297] !== 1'b1 || busy_t[297] !== 1'b0) begin
            failures++; $display("FAIL ntt_done: count=%0d done297=%b busy297=%b required 1 1 0", nd, done_t[297], busy_t[297]);
        end
        checks++; if (wren_t[296] !== 1'b1 || wra_t[296] !== 5'd31 || wrbk_t[296] !== 1'b0) begin
            failures++; $display("FAIL ntt_last_write: wr_en=%b addr=%0d bank=%b required 1 31 0", wren_t[296], wra_t[296], wrbk_t[296]);
        end
        checks++; if (rdbk_t[1+37] !== 1'b1 || wrbk_t[1+37] !== 1'b0) begin
            failures++; $display("FAIL ntt_pass1_banks: rd=%b wr=%b required 1 0", rdbk_t[38], wrbk_t[38]);
        end
        for (int j = 0; j < 32; j++) begin
            checks++; if (tf_t[1+j] !== 8'd0) begin failures++; $display("FAIL ntt_tf_p0[%0d]: got %0d required 0", j, tf_t[1+j]); end
            exp_tf = 8'(3 + j / 8);
            checks++; if (tf_t[1+74+j] !== exp_tf) begin failures++; $display("FAIL ntt_tf_p2[%0d]: got %0d required %0d", j, tf_t[75+j], exp_tf); end
            exp_tf = 8'(31 + j);
            checks++; if (tf_t[1+185+j] !== exp_tf) begin failures++; $display("FAIL ntt_tf_p5[%0d]: got %0d required %0d", j, tf_t[186+j], exp_tf); end
            exp_tf = 8'(63 + j);
            checks++; if (tf_t[1+222+j] !== exp_tf || nl_t[1+222+j] !== 2'd1) begin
                failures++; $display("FAIL ntt_p6[%0d]: tf=%0d ntt_l=%0d required %0d 1", j, tf_t[223+j], nl_t[223+j], exp_tf);
            end
            checks++; if (tf_t[1+259+j] !== exp_tf || nl_t[1+259+j] !== 2'd2) begin
                failures++; $display("FAIL ntt_p7[%0d]: tf=%0d ntt_l=%0d required %0d 2", j, tf_t[260+j], nl_t[260+j], exp_tf);
            end
        end
        checks++; if (tf_t[1+185+33] !== 8'd0 || rden_t[1+185+33] !== 1'b0) begin
            failures++; $display("FAIL ntt_drain_idle_tf: tf=%0d rd_en=%b required 0 0", tf_t[219], rden_t[219]);
        end
    endtask

    task automatic test_intt();
        int ns;
        logic [7:0] exp_tf;
        run_op(2'b01, 300, 0, 2'b00, 0);
        ns = 0;
        for (int k = 1; k <= 300; k++) ns += int'(sel_t[k] === 3'b100);
        checks++; if (ns !== 296 || done_t[297] !== 1'b1) begin
            failures++; $display("FAIL intt_sel_done: sel cycles=%0d done297=%b required 296 1", ns, done_t[297]);
        end
        for (int j = 0; j < 32; j++) begin
            exp_tf = 8'(63 + j);
            checks++; if (tf_t[1+j] !== exp_tf || nl_t[1+j] !== 2'd2) begin
                failures++; $display("FAIL intt_p0[%0d]: tf=%0d ntt_l=%0d required %0d 2", j, tf_t[1+j], nl_t[1+j], exp_tf);
            end
            checks++; if (tf_t[1+259+j] !== 8'd0 || nl_t[1+259+j] !== 2'd0) begin
                failures++; $display("FAIL intt_p7[%0d]: tf=%0d ntt_l=%0d required 0 0", j, tf_t[260+j], nl_t[260+j]);
            end
        end
        checks++; if (wrbk_t[296] !== 1'b0 || wren_t[296] !== 1'b1) begin
            failures++; $display("FAIL intt_final_bank: wr_en=%b bank=%b required 1 0", wren_t[296], wrbk_t[296]);
        end
    endtask

    task automatic test_pointwise(input logic [1:0] o, input logic [2:0] exp_sel);
        int nb;
        logic exp_wen;
        logic [4:0] exp_wa;
        run_op(o, 40, 0, 2'b00, 0);
        nb = 0;
        for (int k = 1; k <= 40; k++) nb += int'(busy_t[k]);
        checks++; if (nb !== 35 || done_t[36] !== 1'b1) begin
            failures++; $display("FAIL pw%0d_timing: busy cycles=%0d done36=%b required 35 1", o, nb, done_t[36]);
        end
        for (int k = 1; k <= 35; k++) begin
            checks++; if (sel_t[k] !== exp_sel || nl_t[k] !== 2'd2 || tf_t[k] !== 8'd0) begin
                failures++; $display("FAIL pw%0d_mode[%0d]: sel=%b ntt_l=%0d tf=%0d required %b 2 0", o, k, sel_t[k], nl_t[k], tf_t[k], exp_sel);
            end
            checks++; if (rden_t[k] !== (k <= 32) || (k <= 32 && (rda_t[k] !== 5'(k-1) || rdbk_t[k] !== 1'b0))) begin
                failures++; $display("FAIL pw%0d_read[%0d]: rd_en=%b addr=%0d bank=%b required %b %0d 0", o, k, rden_t[k], rda_t[k], rdbk_t[k], k <= 32, k-1);
            end
            exp_wen = (k >= 4);
            exp_wa  = 5'(k - 4);
            checks++; if (wren_t[k] !== exp_wen || (exp_wen && (wra_t[k] !== exp_wa || wrbk_t[k] !== 1'b1))) begin
                failures++; $display("FAIL pw%0d_write[%0d]: wr_en=%b addr=%0d bank=%b required %b %0d 1", o, k, wren_t[k], wra_t[k], wrbk_t[k], exp_wen, exp_wa);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int nb, ns, nd;
        run_op(2'b00, 300, 50, 2'b01, 0);
        nb = 0; ns = 0; nd = 0;
        for (int k = 1; k <= 300; k++) begin
            nb += int'(busy_t[k]); ns += int'(sel_t[k] === 3'b001); nd += int'(done_t[k]);
        end
        checks++; if (nb !== 296 || ns !== 296 || nd !== 1 || done_t[297] !== 1'b1) begin
            failures++; $display("FAIL busy_start_ignored: busy=%0d sel001=%0d done=%0d done297=%b required 296 296 1 1", nb, ns, nd, done_t[297]);
        end
        checks++; if (nl_t[1+259] !== 2'd2 || tf_t[1+259] !== 8'd63) begin
            failures++; $display("FAIL busy_start_op_kept: ntt_l=%0d tf=%0d required 2 63", nl_t[260], tf_t[260]);
        end
    endtask

    task automatic test_reset_abort();
        int nw, nd, nb;
        run_op(2'b00, 150, 0, 2'b00, 100);
        checks++; if (wren_t[100] !== 1'b1) begin
            failures++; $display("FAIL abort_pre_write: wr_en=%b required 1", wren_t[100]);
        end
        checks++; if ({busy_t[101], done_t[101], sel_t[101], nl_t[101], tf_t[101], rden_t[101], rda_t[101],
                       rdbk_t[101], wren_t[101], wra_t[101], wrbk_t[101]} !== 28'd0) begin
            failures++; $display("FAIL abort_outputs: busy=%b sel=%b rd_en=%b wr_en=%b wr_addr=%0d bank=%b tf=%0d required all 0",
                                 busy_t[101], sel_t[101], rden_t[101], wren_t[101], wra_t[101], wrbk_t[101], tf_t[101]);
        end
        nw = 0; nd = 0;
        for (int k = 101; k <= 150; k++) begin nw += int'(wren_t[k]); nd += int'(done_t[k]); end
        checks++; if (nw !== 0 || nd !== 0) begin
            failures++; $display("FAIL abort_no_activity: wr_en=%0d done=%0d required 0 0", nw, nd);
        end
        run_op(2'b00, 300, 0, 2'b00, 0);
        nb = 0; nw = 0;
        for (int k = 1; k <= 300; k++) begin nb += int'(busy_t[k]); nw += int'(wren_t[k]); end
        checks++; if (nb !== 296 || nw !== 256 || done_t[297] !== 1'b1) begin
            failures++; $display("FAIL abort_rerun: busy=%0d writes=%0d done297=%b required 296 256 1", nb, nw, done_t[297]);
        end
    endtask

    initial begin
        test_reset();
        test_ntt();
        test_intt();
        test_pointwise(2'b10, 3'b010);
        test_pointwise(2'b11, 3'b110);
        test_start_while_busy();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
